// File: rtl/hwag_coil_scheduler_if.sv
// Bus between the hwag angle base / config master and the coil scheduler.
// The master drives angle, sync, enables and config writes; the scheduler drives coil and status.
interface hwag_coil_scheduler_if #(
  parameter int CH      = 4,
  parameter int ANGLE_W = 16
);
  logic               hwag_start;
  logic [ANGLE_W-1:0] angle;
  logic               rev_pulse;
  logic [CH-1:0]      ch_enable;
  logic               cfg_we;
  logic [2:0]         cfg_ch;
  logic               cfg_sel;
  logic [ANGLE_W-1:0] cfg_data;
  logic               fault_clr;
  logic [CH-1:0]      coil;
  logic [CH-1:0]      dwell_fault;
  logic               cfg_err;

  modport master (
    output hwag_start, angle, rev_pulse, ch_enable,
    output cfg_we, cfg_ch, cfg_sel, cfg_data, fault_clr,
    input  coil, dwell_fault, cfg_err
  );

  modport slave (
    input  hwag_start, angle, rev_pulse, ch_enable,
    input  cfg_we, cfg_ch, cfg_sel, cfg_data, fault_clr,
    output coil, dwell_fault, cfg_err
  );
endinterface

// File: rtl/hwag_coil_scheduler.sv
// Per-channel ignition coil sequencer: charges each coil while the crank angle lies in
// [charge, fire), with revolution-aligned config updates and a dwell-time watchdog.
module hwag_coil_scheduler #(
  parameter int                 CH        = 4,
  parameter int                 ANGLE_W   = 16,
  parameter int                 ANGLE_MAX = 3839,
  parameter int                 DWELL_W   = 24,
  parameter logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(2000000)
) (
  input  logic                   clk,
  input  logic                   rst,
  hwag_coil_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CHARGE,
    S_DONE
  } state_t;

  localparam logic [ANGLE_W-1:0] ANGLE_LAST = ANGLE_W'(ANGLE_MAX);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_MAX - DWELL_W'(1);

  state_t             r_state    [CH];
  logic [ANGLE_W-1:0] r_sh_chg   [CH];
  logic [ANGLE_W-1:0] r_sh_fire  [CH];
  logic [ANGLE_W-1:0] r_act_chg  [CH];
  logic [ANGLE_W-1:0] r_act_fire [CH];
  logic [DWELL_W-1:0] r_dwell    [CH];
  logic [CH-1:0]      r_pending;
  logic [CH-1:0]      r_coil;
  logic [CH-1:0]      r_fault;
  logic               r_cfg_err;

  logic               w_wr_ok;
  logic [CH-1:0]      w_wr_hit;
  logic [CH-1:0]      w_in_win;
  logic [CH-1:0]      w_leave;
  logic [CH-1:0]      w_copy;
  logic [CH-1:0]      w_fault_set;

  // Unsigned window test; a wrapped window (chg > fire) spans the gap point.
  function automatic logic in_window(input logic [ANGLE_W-1:0] a,
                                     input logic [ANGLE_W-1:0] chg,
                                     input logic [ANGLE_W-1:0] fire);
    if (chg <= fire) return (a >= chg) && (a < fire);
    else             return (a >= chg) || (a < fire);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    w_wr_ok     = bus.cfg_we && (bus.cfg_data <= ANGLE_LAST) && (int'(bus.cfg_ch) < CH);
    w_wr_hit    = '0;
    w_in_win    = '0;
    w_leave     = '0;
    w_copy      = '0;
    w_fault_set = '0;
    for (int i = 0; i < CH; i++) begin
      w_wr_hit[i]    = w_wr_ok && (int'(bus.cfg_ch) == i);
      w_in_win[i]    = in_window(bus.angle, r_act_chg[i], r_act_fire[i]);
      // CHARGE exit condition; a charging channel picks up new angles only when it leaves.
      w_leave[i]     = !bus.hwag_start || !bus.ch_enable[i] || !w_in_win[i] ||
                       (r_dwell[i] == DWELL_LAST);
      w_copy[i]      = (r_state[i] == S_CHARGE) ? w_leave[i] : bus.rev_pulse;
      w_fault_set[i] = (r_state[i] == S_CHARGE) && bus.hwag_start && bus.ch_enable[i] &&
                       w_in_win[i] && (r_dwell[i] == DWELL_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the angle arrays are reset on purpose; every channel must come up with an empty window.
      for (int i = 0; i < CH; i++) begin
        r_state[i]    <= S_IDLE;
        r_sh_chg[i]   <= '0;
        r_sh_fire[i]  <= '0;
        r_act_chg[i]  <= '0;
        r_act_fire[i] <= '0;
        r_dwell[i]    <= '0;
      end
      r_pending <= '0;
      r_coil    <= '0;
      r_fault   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
      r_cfg_err <= bus.cfg_we && !w_wr_ok;
      for (int i = 0; i < CH; i++) begin
        if (w_wr_hit[i]) begin
          if (bus.cfg_sel) r_sh_fire[i] <= bus.cfg_data;
          else             r_sh_chg[i]  <= bus.cfg_data;
        end
        // Copy takes the pre-write shadow; a same-clock write keeps pending set.
        if (w_copy[i] && r_pending[i]) begin
          r_act_chg[i]  <= r_sh_chg[i];
          r_act_fire[i] <= r_sh_fire[i];
        end
        r_pending[i] <= w_wr_hit[i] || (r_pending[i] && !w_copy[i]);
        r_fault[i]   <= w_fault_set[i] || (r_fault[i] && !bus.fault_clr);

        if (!bus.hwag_start || !bus.ch_enable[i]) begin
          r_state[i] <= S_IDLE;
          r_coil[i]  <= 1'b0;
        end else begin
          unique case (r_state[i])
            S_IDLE: begin
              if (!w_in_win[i]) r_state[i] <= S_ARMED;
            end
            S_ARMED: begin
              if (w_in_win[i]) begin
                r_state[i] <= S_CHARGE;
                r_coil[i]  <= 1'b1;
                r_dwell[i] <= '0;
              end
            end
            S_CHARGE: begin
              if (w_leave[i]) begin
                r_state[i] <= S_DONE;
                r_coil[i]  <= 1'b0;
              end else if (r_dwell[i] != '1) begin
                r_dwell[i] <= r_dwell[i] + 1'b1;
              end
            end
            S_DONE: begin
              if (!w_in_win[i]) r_state[i] <= S_ARMED;
            end
            default: begin
              r_state[i] <= S_IDLE;
              r_coil[i]  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.coil        = r_coil;
  assign bus.dwell_fault = r_fault;
  assign bus.cfg_err     = r_cfg_err;

endmodule
